// File: rtl/hdmi_box_cfg_arbiter.sv
// Frame-synchronous overlay-box geometry arbiter: round-robin grant, validate/clamp, commit on vs fall.
// Latency: accept -> clamp -> commit on the next frame boundary (>= 3 edges); one request pending at most.
// Backpressure: both readies drop from accept until the commit edge; ready is only offered in IDLE.
module hdmi_box_cfg_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DEF_X    = 270,
    parameter int DEF_Y    = 190,
    parameter int DEF_W    = 100,
    parameter int DEF_H    = 80,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vs,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [11:0]      req0_x,
    input  logic [11:0]      req0_y,
    input  logic [11:0]      req0_w,
    input  logic [11:0]      req0_h,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [11:0]      req1_x,
    input  logic [11:0]      req1_y,
    input  logic [11:0]      req1_w,
    input  logic [11:0]      req1_h,
    output logic [11:0]      box_x,
    output logic [11:0]      box_y,
    output logic [11:0]      box_w,
    output logic [11:0]      box_h,
    output logic             box_src,
    output logic             commit,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
    } geom_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAMP = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [12:0] H_LIM  = 13'(H_ACTIVE);
    localparam logic [12:0] V_LIM  = 13'(V_ACTIVE);
    localparam logic [12:0] H_LAST = 13'(H_ACTIVE - 1);
    localparam logic [12:0] V_LAST = 13'(V_ACTIVE - 1);

    state_t state;
    logic   vs_d;
    logic   fs;
    logic   last_grant;
    logic   sel;
    logic   grant_valid;
    geom_t  grant_geom;
    geom_t  pend;
    logic   pend_src;
    logic   pend_bad;
    geom_t  pend_clamped;
    logic [12:0] sum_x;
    logic [12:0] sum_y;

    assign fs = vs_d & ~vs;

    // A lone requester wins outright; a tie (or no request) goes to whoever did not win last.
    always_comb begin
        sel = ~last_grant;
        if (req0_valid && !req1_valid) begin
            sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready  = (state == IDLE) && !sel;
    assign req1_ready  = (state == IDLE) && sel;
    assign grant_valid = sel ? req1_valid : req0_valid;
    assign grant_geom  = sel ? geom_t'{req1_x, req1_y, req1_w, req1_h}
                             : geom_t'{req0_x, req0_y, req0_w, req0_h};

    assign sum_x = {1'b0, pend.x} + {1'b0, pend.w};
    assign sum_y = {1'b0, pend.y} + {1'b0, pend.h};

    assign pend_bad = ({1'b0, pend.x} >= H_LIM) || ({1'b0, pend.y} >= V_LIM) ||
                      (pend.w == 12'd0) || (pend.h == 12'd0);

    // Origin is already known to be inside the active area, so the trimmed size fits in 12 bits.
    always_comb begin
        pend_clamped = pend;
        if (sum_x > H_LAST) begin
            pend_clamped.w = H_LAST[11:0] - pend.x;
        end
        if (sum_y > V_LAST) begin
            pend_clamped.h = V_LAST[11:0] - pend.y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pend       <= '0;
            pend_src   <= 1'b0;
            last_grant <= 1'b1;
            box_x      <= 12'(DEF_X);
            box_y      <= 12'(DEF_Y);
            box_w      <= 12'(DEF_W);
            box_h      <= 12'(DEF_H);
            box_src    <= 1'b0;
            commit     <= 1'b0;
            err        <= 1'b0;
        end else begin
            commit <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        pend       <= grant_geom;
                        pend_src   <= sel;
                        last_grant <= sel;
                        state      <= CLAMP;
                    end
                end
                CLAMP: begin
                    if (pend_bad) begin
                        err   <= 1'b1;
                        pend  <= '0;
                        state <= IDLE;
                    end else begin
                        pend  <= pend_clamped;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fs) begin
                        box_x   <= pend.x;
                        box_y   <= pend.y;
                        box_w   <= pend.w;
                        box_h   <= pend.h;
                        box_src <= pend_src;
                        commit  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_d      <= 1'b1;
            frame_cnt <= '0;
        end else begin
            vs_d <= vs;
            if (fs) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_box_cfg_arbiter.sv
// Directed bench for hdmi_box_cfg_arbiter: vector table plus hand-written frame-boundary sequences.
module tb_hdmi_box_cfg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_x, req0_y, req0_w, req0_h;
    logic [11:0] req1_x, req1_y, req1_w, req1_h;
    logic [11:0] box_x, box_y, box_w, box_h;
    logic        box_src, commit, err;
    logic [15:0] frame_cnt;

    logic        n_r0_ready, n_r1_ready, n_src, n_commit, n_err;
    logic [11:0] n_bx, n_by, n_bw, n_bh;
    logic [3:0]  n_frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    hdmi_box_cfg_arbiter u_dut (
        .clk(clk), .reset(reset), .vs(vs),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_w(req0_w), .req0_h(req0_h),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_w(req1_w), .req1_h(req1_h),
        .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .box_src(box_src), .commit(commit), .err(err), .frame_cnt(frame_cnt)
    );

    // Narrow frame counter so the wrap can be reached in a few frames.
    hdmi_box_cfg_arbiter #(.CNT_W(4)) u_narrow (
        .clk(clk), .reset(reset), .vs(vs),
        .req0_valid(1'b0), .req0_ready(n_r0_ready),
        .req0_x(12'd0), .req0_y(12'd0), .req0_w(12'd0), .req0_h(12'd0),
        .req1_valid(1'b0), .req1_ready(n_r1_ready),
        .req1_x(12'd0), .req1_y(12'd0), .req1_w(12'd0), .req1_h(12'd0),
        .box_x(n_bx), .box_y(n_by), .box_w(n_bw), .box_h(n_bh),
        .box_src(n_src), .commit(n_commit), .err(n_err), .frame_cnt(n_frame_cnt)
    );

    typedef struct packed {
        logic        src;
        logic [11:0] x, y, w, h;
        logic        exp_err;
        logic [11:0] ex, ey, ew, eh;
        logic        esrc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fs_pulse(output logic c, output logic e, output logic r0, output logic r1);
        vs = 1'b0;
        tick();
        c  = commit;
        e  = err;
        r0 = req0_ready;
        r1 = req1_ready;
        vs = 1'b1;
        exp_fc++;
        tick();
        chk("commit_one_cycle", {31'd0, commit}, 32'd0);
    endtask

    task automatic do_req(input logic src, input logic [11:0] x, input logic [11:0] y,
                          input logic [11:0] w, input logic [11:0] h);
        logic ok;
        logic rdy;
        ok = 1'b0;
        if (src) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_w = w; req1_h = h;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_w = w; req0_h = h;
        end
        #1;
        for (int n = 0; n < 20; n++) begin
            rdy = src ? req1_ready : req0_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic c, e, r0, r1;
        logic [11:0] px, py, pw, ph;
        logic psrc;

        vecs[0] = '{1'b0, 12'd10,  12'd20,  12'd50,  12'd40,  1'b0, 12'd10,  12'd20,  12'd50,  12'd40,  1'b0};
        vecs[1] = '{1'b1, 12'd600, 12'd470, 12'd100, 12'd100, 1'b0, 12'd600, 12'd470, 12'd39,  12'd9,   1'b1};
        vecs[2] = '{1'b0, 12'd700, 12'd10,  12'd5,   12'd5,   1'b1, 12'd600, 12'd470, 12'd39,  12'd9,   1'b1};
        vecs[3] = '{1'b0, 12'd10,  12'd10,  12'd0,   12'd5,   1'b1, 12'd600, 12'd470, 12'd39,  12'd9,   1'b1};
        vecs[4] = '{1'b1, 12'd0,   12'd0,   12'd640, 12'd480, 1'b0, 12'd0,   12'd0,   12'd639, 12'd479, 1'b1};
        vecs[5] = '{1'b0, 12'd639, 12'd479, 12'd1,   12'd1,   1'b0, 12'd639, 12'd479, 12'd0,   12'd0,   1'b0};
        vecs[6] = '{1'b1, 12'd5,   12'd480, 12'd10,  12'd10,  1'b1, 12'd639, 12'd479, 12'd0,   12'd0,   1'b0};
        vecs[7] = '{1'b0, 12'd100, 12'd200, 12'd300, 12'd100, 1'b0, 12'd100, 12'd200, 12'd300, 12'd100, 1'b0};

        reset = 1'b1; vs = 1'b1;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_w = '0; req0_h = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_w = '0; req1_h = '0;
        #1 reset = 1'b0;
        #20 reset = 1'b1;
        tick();

        chk("rst box_x", box_x, 270);
        chk("rst box_y", box_y, 190);
        chk("rst box_w", box_w, 100);
        chk("rst box_h", box_h, 80);
        chk("rst box_src", box_src, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst req0_ready", req0_ready, 1);
        chk("rst req1_ready", req1_ready, 0);
        chk("rst commit", commit, 0);
        chk("rst err", err, 0);

        px = 12'd270; py = 12'd190; pw = 12'd100; ph = 12'd80; psrc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].src, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
            chk($sformatf("v%0d clamp readies", i), {30'd0, req0_ready, req1_ready}, 0);
            tick();
            chk($sformatf("v%0d err", i), err, vecs[i].exp_err);
            if (!vecs[i].exp_err)
                chk($sformatf("v%0d wait readies", i), {30'd0, req0_ready, req1_ready}, 0);
            chk($sformatf("v%0d box_x pre-fs", i), box_x, px);
            chk($sformatf("v%0d box_w pre-fs", i), box_w, pw);
            fs_pulse(c, e, r0, r1);
            chk($sformatf("v%0d commit", i), c, !vecs[i].exp_err);
            chk($sformatf("v%0d err after 1 cycle", i), e, 0);
            chk($sformatf("v%0d box_x", i), box_x, vecs[i].ex);
            chk($sformatf("v%0d box_y", i), box_y, vecs[i].ey);
            chk($sformatf("v%0d box_w", i), box_w, vecs[i].ew);
            chk($sformatf("v%0d box_h", i), box_h, vecs[i].eh);
            chk($sformatf("v%0d box_src", i), box_src, vecs[i].esrc);
            px = vecs[i].ex; py = vecs[i].ey; pw = vecs[i].ew; ph = vecs[i].eh; psrc = vecs[i].esrc;
        end
        chk("frame_cnt after table", frame_cnt, exp_fc);

        // Round-robin from a fresh reset: both requesters hold valid throughout.
        reset = 1'b0;
        req0_valid = 1'b1; req0_x = 12'd1; req0_y = 12'd1; req0_w = 12'd1; req0_h = 12'd1;
        req1_valid = 1'b1; req1_x = 12'd2; req1_y = 12'd2; req1_w = 12'd2; req1_h = 12'd2;
        #2 reset = 1'b1;
        exp_fc = 0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            chk($sformatf("rr%0d wait readies", i), {30'd0, req0_ready, req1_ready}, 0);
            fs_pulse(c, e, r0, r1);
            chk($sformatf("rr%0d commit", i), c, 1);
            chk($sformatf("rr%0d box_src", i), box_src, i % 2);
            chk($sformatf("rr%0d box_x", i), box_x, (i % 2) ? 2 : 1);
            chk($sformatf("rr%0d idle readies", i), {30'd0, r0, r1}, (i % 2) ? 2 : 1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // A src-0 request was accepted on the last round-robin edge; let it reach WAIT, then reset.
        tick();
        reset = 1'b0;
        #1;
        exp_fc = 0;
        chk("midrst box_x", box_x, 270);
        chk("midrst box_h", box_h, 80);
        chk("midrst frame_cnt", frame_cnt, 0);
        chk("midrst commit", commit, 0);
        #2 reset = 1'b1;
        tick();
        fs_pulse(c, e, r0, r1);
        chk("midrst no commit", c, 0);
        chk("midrst box_x kept", box_x, 270);
        chk("midrst frame_cnt", frame_cnt, exp_fc);

        // Request sits in CLAMP on the fs edge: that boundary must not commit it.
        do_req(1'b0, 12'd30, 12'd40, 12'd50, 12'd60);
        vs = 1'b0;
        tick();
        exp_fc++;
        chk("clampfs commit", commit, 0);
        chk("clampfs box_x", box_x, 270);
        vs = 1'b1;
        tick();
        fs_pulse(c, e, r0, r1);
        chk("clampfs late commit", c, 1);
        chk("clampfs box_x", box_x, 30);
        chk("clampfs box_h", box_h, 60);
        chk("clampfs frame_cnt", frame_cnt, exp_fc);

        // Counter wrap on the narrow instance.
        reset = 1'b0;
        #2 reset = 1'b1;
        exp_fc = 0;
        repeat (15) fs_pulse(c, e, r0, r1);
        chk("narrow cnt 15", n_frame_cnt, 15);
        fs_pulse(c, e, r0, r1);
        chk("narrow cnt wrap", n_frame_cnt, 0);
        chk("main cnt 16", frame_cnt, exp_fc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
